hdr_insert_sched: RTL and testbench

- Shares the single header-insert port of the AXI-Stream header inserter between NUM_REQ header requesters, granting one header per packet.
- Round-robin arbitration; the winner's header is captured into holding registers, presented on the insert port, and the grant is held until the packet's last beat leaves the inserter's output.
- Sits between the per-source header generators and the inserter's valid_insert/data_insert/keep_insert/byte_insert_cnt/ready_insert port.
- Passively monitors the inserter's output handshake.

---
 rtl/hdr_insert_sched.sv | 135 +++++++++++++
 tb/tb_hdr_insert_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hdr_insert_sched.sv
// Round-robin scheduler that shares the header-insert port of the AXI-Stream header
// inserter between NUM_REQ header sources, holding the grant until the packet's last beat.
module hdr_insert_sched #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_REQ      = 4,
    parameter int ID_WD        = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]           req_data,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0]      req_keep,
    input  logic [NUM_REQ*(BYTE_CNT_WD+1)-1:0]   req_byte_cnt,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 ins_valid,
    output logic [DATA_WD-1:0]                   ins_data,
    output logic [DATA_BYTE_WD-1:0]              ins_keep,
    output logic [BYTE_CNT_WD:0]                 ins_byte_cnt,
    input  logic                                 ins_ready,
    input  logic                                 mon_valid,
    input  logic                                 mon_ready,
    input  logic                                 mon_last,
    output logic [ID_WD-1:0]                     grant_id,
    output logic                                 busy,
    output logic                                 hdr_err,
    output logic [15:0]                          pkt_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] PKT  = 2'd2;

    localparam logic [BYTE_CNT_WD:0] MAX_CNT = (BYTE_CNT_WD+1)'(DATA_BYTE_WD);

    // A header is usable only with a non-zero, in-range count matching a right-aligned keep.
    function automatic logic hdr_bad(input logic [DATA_BYTE_WD-1:0] keep,
                                     input logic [BYTE_CNT_WD:0]    cnt);
        logic [BYTE_CNT_WD:0]    ones;
        logic [DATA_BYTE_WD-1:0] keep_inc;
        ones = '0;
        for (int b = 0; b < DATA_BYTE_WD; b++) begin
            ones = ones + (BYTE_CNT_WD+1)'(keep[b]);
        end
        keep_inc = keep + DATA_BYTE_WD'(1);
        return (cnt == '0) || (cnt > MAX_CNT) || (cnt != ones) || ((keep & keep_inc) != '0);
    endfunction

    logic [1:0]              state;
    logic [ID_WD-1:0]        rr_ptr;
    logic                    win_found;
    logic [ID_WD-1:0]        win_id;
    logic [ID_WD-1:0]        rr_next;
    logic [DATA_WD-1:0]      win_data;
    logic [DATA_BYTE_WD-1:0] win_keep;
    logic [BYTE_CNT_WD:0]    win_cnt;
    logic                    win_bad;

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_WD'(idx);
            end
        end
    end

    assign win_data = req_data[int'(win_id)*DATA_WD +: DATA_WD];
    assign win_keep = req_keep[int'(win_id)*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign win_cnt  = req_byte_cnt[int'(win_id)*(BYTE_CNT_WD+1) +: BYTE_CNT_WD+1];
    assign win_bad  = hdr_bad(win_keep, win_cnt);
    assign rr_next  = (win_id == ID_WD'(NUM_REQ - 1)) ? '0 : win_id + ID_WD'(1);

    // Gated by rst_n so every output reads zero while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign ins_valid = (state == HDR);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            ins_data     <= '0;
            ins_keep     <= '0;
            ins_byte_cnt <= '0;
            hdr_err      <= 1'b0;
            pkt_cnt      <= '0;
        end else begin
            hdr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        rr_ptr       <= rr_next;
                        grant_id     <= win_id;
                        ins_data     <= win_data;
                        ins_keep     <= win_keep;
                        ins_byte_cnt <= win_cnt;
                        if (win_bad) begin
                            hdr_err <= 1'b1;
                        end else begin
                            state <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (ins_ready) begin
                        state <= PKT;
                    end
                end
                PKT: begin
                    if (mon_valid && mon_ready && mon_last) begin
                        pkt_cnt <= pkt_cnt + 16'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdr_insert_sched.sv
// Cycle-vector bench for hdr_insert_sched: a table of per-cycle inputs and expected
// outputs, followed by an asynchronous-reset-during-packet sequence.
module tb_hdr_insert_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [127:0] req_data;
    logic [15:0] req_keep;
    logic [11:0] req_byte_cnt;
    logic [3:0]  req_ready;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [3:0]  ins_keep;
    logic [2:0]  ins_byte_cnt;
    logic        ins_ready;
    logic        mon_valid;
    logic        mon_ready;
    logic        mon_last;
    logic [1:0]  grant_id;
    logic        busy;
    logic        hdr_err;
    logic [15:0] pkt_cnt;

    hdr_insert_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_keep(req_keep),
        .req_byte_cnt(req_byte_cnt), .req_ready(req_ready),
        .ins_valid(ins_valid), .ins_data(ins_data), .ins_keep(ins_keep),
        .ins_byte_cnt(ins_byte_cnt), .ins_ready(ins_ready),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
        .grant_id(grant_id), .busy(busy), .hdr_err(hdr_err), .pkt_cnt(pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic        ir, mv, mr, ml, bad2;
        logic [3:0]  e_rr;
        logic        e_iv;
        logic [1:0]  e_gid;
        logic        e_busy, e_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] hdr[4];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] rv, input logic ir, mv, mr, ml, bad2,
                       input logic [3:0] e_rr, input logic e_iv, input logic [1:0] e_gid,
                       input logic e_busy, e_err, input logic [15:0] e_cnt);
        vec_t v;
        v = '{rv, ir, mv, mr, ml, bad2, e_rr, e_iv, e_gid, e_busy, e_err, e_cnt};
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        req_valid    = v.rv;
        ins_ready    = v.ir;
        mon_valid    = v.mv;
        mon_ready    = v.mr;
        mon_last     = v.ml;
        req_keep     = v.bad2 ? {4'hF, 4'h3, 4'hF, 4'hF} : 16'hFFFF;
        req_byte_cnt = v.bad2 ? {3'd4, 3'd3, 3'd4, 3'd4} : {4{3'd4}};
    endtask

    initial begin
        logic [1:0]  gprev;
        logic [15:0] c;
        vec_t        idle_v;

        hdr[0] = 32'h11110000;
        hdr[1] = 32'hA1B2C3D4;
        hdr[2] = 32'h22220002;
        hdr[3] = 32'h33330003;
        req_data = {hdr[3], hdr[2], hdr[1], hdr[0]};
        idle_v = '{4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0};
        drive(idle_v);
        rst_n = 1'b0;

        // All four requesting continuously: five packets granted 0,1,2,3,0.
        gprev = 2'd0;
        c = 16'd0;
        for (int p = 0; p < 5; p++) begin
            add(4'hF, 0, 0, 0, 0, 0, 4'(1 << (p % 4)), 0, gprev, 0, 0, c);
            add(4'hF, 1, 0, 0, 0, 0, 4'b0, 1, 2'(p % 4), 1, 0, c);
            add(4'hF, 0, 1, 1, 1, 0, 4'b0, 0, 2'(p % 4), 1, 0, c);
            gprev = 2'(p % 4);
            c++;
        end
        // Single requester 1 with a 3-beat packet.
        add(4'b0010, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 5);
        add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 1, 0, 5);
        add(4'b0000, 1, 0, 0, 0, 0, 4'b0000, 1, 1, 1, 0, 5);
        add(4'b0000, 0, 1, 1, 0, 0, 4'b0000, 0, 1, 1, 0, 5);
        add(4'b0000, 0, 1, 1, 0, 0, 4'b0000, 0, 1, 1, 0, 5);
        add(4'b0000, 0, 1, 1, 1, 0, 4'b0000, 0, 1, 1, 0, 5);
        add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0, 6);
        // Inserter stalls 5 cycles in HDR while others keep requesting.
        add(4'hF, 0, 0, 0, 0, 0, 4'b0100, 0, 1, 0, 0, 6);
        for (int s = 0; s < 5; s++) add(4'hF, 0, 0, 0, 0, 0, 4'b0, 1, 2, 1, 0, 6);
        add(4'hF, 1, 0, 0, 0, 0, 4'b0000, 1, 2, 1, 0, 6);
        add(4'hF, 0, 1, 1, 1, 0, 4'b0000, 0, 2, 1, 0, 6);
        add(4'h0, 0, 0, 0, 0, 0, 4'b0000, 0, 2, 0, 0, 7);
        // Malformed header from requester 2, then requester 3 wins.
        add(4'b0100, 0, 0, 0, 0, 1, 4'b0100, 0, 2, 0, 0, 7);
        add(4'b1100, 0, 0, 0, 0, 0, 4'b1000, 0, 2, 0, 1, 7);
        add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 3, 1, 0, 7);
        add(4'b0000, 1, 0, 0, 0, 0, 4'b0000, 1, 3, 1, 0, 7);
        add(4'b0000, 0, 1, 1, 1, 0, 4'b0000, 0, 3, 1, 0, 7);
        // Last-beat handshakes in HDR and without mon_ready are not counted.
        add(4'b0001, 0, 0, 0, 0, 0, 4'b0001, 0, 3, 0, 0, 8);
        add(4'b0000, 0, 1, 1, 1, 0, 4'b0000, 1, 0, 1, 0, 8);
        add(4'b0000, 1, 1, 1, 1, 0, 4'b0000, 1, 0, 1, 0, 8);
        add(4'b0000, 0, 1, 0, 1, 0, 4'b0000, 0, 0, 1, 0, 8);
        add(4'b0000, 0, 1, 1, 1, 0, 4'b0000, 0, 0, 1, 0, 8);
        add(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 9);

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_ins_valid", 32'(ins_valid), 0);
        chk("rst_ins_data", ins_data, 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vq[i]);
            @(negedge clk);
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vq[i].e_rr));
            chk($sformatf("v%0d_ins_valid", i), 32'(ins_valid), 32'(vq[i].e_iv));
            chk($sformatf("v%0d_grant_id", i), 32'(grant_id), 32'(vq[i].e_gid));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].e_busy));
            chk($sformatf("v%0d_hdr_err", i), 32'(hdr_err), 32'(vq[i].e_err));
            chk($sformatf("v%0d_pkt_cnt", i), 32'(pkt_cnt), 32'(vq[i].e_cnt));
            if (vq[i].e_iv) begin
                chk($sformatf("v%0d_ins_data", i), ins_data, hdr[vq[i].e_gid]);
                chk($sformatf("v%0d_ins_keep", i), 32'(ins_keep), 32'hF);
                chk($sformatf("v%0d_ins_cnt", i), 32'(ins_byte_cnt), 32'd4);
            end
        end

        // Asynchronous reset in PKT with requester 0 still pending.
        idle_v.rv = 4'b0001;
        @(posedge clk); #1; drive(idle_v);
        @(negedge clk);
        chk("ar_req_ready", 32'(req_ready), 32'b0001);
        idle_v.ir = 1'b1;
        @(posedge clk); #1; drive(idle_v);
        @(negedge clk);
        chk("ar_ins_valid", 32'(ins_valid), 1);
        idle_v.ir = 1'b0;
        idle_v.mv = 1'b1;
        idle_v.mr = 1'b1;
        @(posedge clk); #1; drive(idle_v);
        @(negedge clk);
        chk("ar_busy_pkt", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_ins_valid_rst", 32'(ins_valid), 0);
        chk("ar_req_ready_rst", 32'(req_ready), 0);
        chk("ar_pkt_cnt", 32'(pkt_cnt), 0);
        chk("ar_grant_id", 32'(grant_id), 0);
        chk("ar_ins_data", ins_data, 0);
        chk("ar_hdr_err", 32'(hdr_err), 0);
        idle_v.mv = 1'b0;
        idle_v.mr = 1'b0;
        drive(idle_v);
        rst_n = 1'b1;
        #1;
        chk("ar_req_ready_rel", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        idle_v.rv = 4'b0000;
        drive(idle_v);
        @(negedge clk);
        chk("ar_regrant_valid", 32'(ins_valid), 1);
        chk("ar_regrant_id", 32'(grant_id), 0);
        chk("ar_regrant_data", ins_data, hdr[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
